// File: rtl/link_pkg.sv
// Shared client-link definitions: FSM encoding, byte width,
// request codes and the assembled request bundle.
package link_pkg;

  localparam int BYTE_W = 8;

  localparam logic [0:0] WAIT_CODE = 1'b0;
  localparam logic [0:0] WAIT_ADDR = 1'b1;

  localparam logic [BYTE_W-1:0] REQ_READ   = 8'h01;
  localparam logic [BYTE_W-1:0] REQ_WRITE  = 8'h02;
  localparam logic [BYTE_W-1:0] REQ_STATUS = 8'h03;
  localparam logic [BYTE_W-1:0] REQ_RESET  = 8'h04;

  typedef struct packed {
    logic [BYTE_W-1:0] code;
    logic [BYTE_W-1:0] addr;
  } request_t;

endpackage

// File: rtl/request_assembler_timeout_counter.sv
// Gap timer between the code byte and the address byte;
// terminal flags the last permitted cycle.
module timeout_counter #(
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign terminal = (count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/request_assembler.sv
// Collects {code, address} byte pairs from UART_RX and holds
// each request in a 1-deep valid/accept output register.
module request_assembler
  import link_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              rx_done,
  input  logic [BYTE_W-1:0] rx_byte,
  input  logic              request_accept,
  output logic              request_valid,
  output logic [BYTE_W-1:0] request_code,
  output logic [BYTE_W-1:0] sensor_address,
  output logic              timeout,
  output logic              overrun
);

  logic [0:0]        state;
  logic [BYTE_W-1:0] code_buf;
  request_t          held;
  logic              terminal;
  logic              complete;
  logic              expire;
  logic              load;

  assign complete = (state == WAIT_ADDR) && rx_done;
  assign expire   = (state == WAIT_ADDR) && !rx_done && terminal;
  assign load     = complete && (!request_valid || request_accept);

  timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   ((state == WAIT_CODE) && rx_done),
    .enable  ((state == WAIT_ADDR) && !rx_done && !terminal),
    .terminal(terminal)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state    <= WAIT_CODE;
      code_buf <= '0;
    end else begin
      unique case (1'b1)
        (state == WAIT_CODE): begin
          if (rx_done) begin
            code_buf <= rx_byte;
            state    <= WAIT_ADDR;
          end
        end
        (state == WAIT_ADDR): begin
          if (rx_done || terminal) begin
            state <= WAIT_CODE;
          end
        end
        default: state <= WAIT_CODE;
      endcase
    end
  end

  // Accept and a new completion in the same cycle hand over seamlessly.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      request_valid <= 1'b0;
      held          <= '0;
      timeout       <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      timeout <= expire;
      overrun <= complete && request_valid && !request_accept;
      if (load) begin
        request_valid <= 1'b1;
        held          <= '{code: code_buf, addr: rx_byte};
      end else if (request_accept) begin
        request_valid <= 1'b0;
      end
    end
  end

  assign request_code   = held.code;
  assign sensor_address = held.addr;

endmodule
